norm_round_fp: RTL and testbench

- Normalize/round datapath that responds to the FP multiply controller's normalizer channel.
- Accepts the controller's normalize enable, clear strobe and source-select; returns normalize-done and a renormalize request.
- Takes the raw mantissa product and pre-biased exponent from the mantissa multiplier, and produces a normalized, round-to-nearest-even, biased FP fraction/exponent pair.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/round_rne_fp.sv | 19 +
 rtl/norm_round_fp.sv | 137 +++++++++++++
 tb/tb_norm_round_fp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP field-width derivations, normalizer state encoding and saturation helpers.
package fp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } norm_state_t;

   function automatic int exp_w(input int size);
      return 5 + ($clog2(size) - 4) * 3;
   endfunction

   function automatic int frac_w(input int size);
      return size - exp_w(size) - 1;
   endfunction

   function automatic int bias_of(input int exponent);
      return 2 ** (exponent - 1) - 1;
   endfunction

   function automatic int prod_w(input int fraction);
      return 2 * (fraction + 1);
   endfunction

   // Largest biased exponent; results at or above it saturate to infinity.
   function automatic int exp_max(input int bias);
      return 2 * bias + 1;
   endfunction

endpackage

// File: rtl/round_rne_fp.sv
// Round-to-nearest-even of a mantissa with guard/sticky; carry flags a mantissa overflow.
module round_rne_fp #(
   parameter int FRACTION = 52
) (
   input  logic [FRACTION:0]   mant,
   input  logic                guard,
   input  logic                sticky,
   output logic [FRACTION+1:0] r,
   output logic                carry
);

   logic inc;

   // Ties go up only when the kept LSB is odd.
   assign inc   = guard & (sticky | mant[0]);
   assign r     = {1'b0, mant} + {{(FRACTION+1){1'b0}}, inc};
   assign carry = r[FRACTION+1];

endmodule

// File: rtl/norm_round_fp.sv
// Normalizer channel of the FP multiplier: shifts the raw product left until its MSB
// is set, rounds to nearest-even and saturates/flushes the biased result.
module norm_round_fp
   import fp_pkg::*;
#(
   parameter int  SIZE     = 64,
   parameter int  EXPONENT = exp_w(SIZE),
   parameter int  FRACTION = SIZE - EXPONENT - 1,
   parameter int  BIAS     = bias_of(EXPONENT),
   localparam int PW       = prod_w(FRACTION)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_en_norm,
   input  logic                       i_rst_norm_n,
   input  logic                       i_mux_norm,
   input  logic [PW-1:0]              i_prod,
   input  logic signed [EXPONENT+1:0] i_exp,
   output logic [FRACTION-1:0]        o_fraction,
   output logic [EXPONENT-1:0]        o_exponent,
   output logic                       o_normal_done,
   output logic                       o_round,
   output logic                       o_overflow,
   output logic                       o_underflow,
   output norm_state_t                o_state
);

   localparam int EW = EXPONENT + 2;
   localparam logic signed [EW-1:0] E_SAT = EW'(exp_max(BIAS));

   norm_state_t               state_q, state_d;
   logic [PW-1:0]             w_q;
   logic signed [EW-1:0]      e_q;
   logic [FRACTION+1:0]       r_q;
   logic [FRACTION:0]         mant;
   logic                      guard, sticky, carry, w_zero, norm_ok;
   logic [FRACTION+1:0]       r_rnd;

   assign mant    = {1'b1, w_q[PW-2 -: FRACTION]};
   assign guard   = w_q[PW-FRACTION-2];
   assign sticky  = |w_q[PW-FRACTION-3:0];
   assign w_zero  = (w_q == '0);
   assign norm_ok = w_q[PW-1] | w_zero;
   assign o_state = state_q;

   round_rne_fp #(.FRACTION(FRACTION)) u_round (
      .mant   (mant),
      .guard  (guard),
      .sticky (sticky),
      .r      (r_rnd),
      .carry  (carry)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Controller protocol: a low i_rst_norm_n loads and restarts from any state and
   // outranks i_en_norm; i_en_norm only advances the shift/round step.
   always_comb begin
      state_d = state_q;
      if (!i_rst_norm_n) begin
         state_d = ST_SHIFT;
      end else begin
         case (state_q)
            ST_SHIFT: if (i_en_norm && norm_ok) state_d = ST_DONE;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         w_q           <= '0;
         e_q           <= '0;
         r_q           <= '0;
         o_fraction    <= '0;
         o_exponent    <= '0;
         o_normal_done <= 1'b0;
         o_round       <= 1'b0;
         o_overflow    <= 1'b0;
         o_underflow   <= 1'b0;
      end else if (!i_rst_norm_n) begin
         if (i_mux_norm) begin
            w_q <= i_prod;
            e_q <= i_exp + EW'(1);
         end else begin
            // Renormalize: the carried-out rounded mantissa re-enters one place lower.
            w_q <= {r_q, {(PW-FRACTION-2){1'b0}}};
            e_q <= e_q + EW'(1);
         end
         o_normal_done <= 1'b0;
         o_round       <= 1'b0;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (i_en_norm) begin
                  if (norm_ok) begin
                     r_q     <= r_rnd;
                     o_round <= carry;
                     if (!carry) begin
                        if (w_zero) begin
                           o_fraction  <= '0;
                           o_exponent  <= '0;
                           o_overflow  <= 1'b0;
                           o_underflow <= 1'b0;
                        end else if (e_q >= E_SAT) begin
                           o_fraction  <= '0;
                           o_exponent  <= '1;
                           o_overflow  <= 1'b1;
                           o_underflow <= 1'b0;
                        end else if (e_q <= EW'(0)) begin
                           o_fraction  <= '0;
                           o_exponent  <= '0;
                           o_overflow  <= 1'b0;
                           o_underflow <= 1'b1;
                        end else begin
                           o_fraction  <= r_rnd[FRACTION-1:0];
                           o_exponent  <= e_q[EXPONENT-1:0];
                           o_overflow  <= 1'b0;
                           o_underflow <= 1'b0;
                        end
                     end
                  end else begin
                     w_q <= w_q << 1;
                     e_q <= e_q - EW'(1);
                  end
               end
            end
            ST_DONE: o_normal_done <= 1'b1;
            default: o_normal_done <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_norm_round_fp.sv
// Bench for norm_round_fp at SIZE=16: directed vector table, control corner cases and
// randomized products checked against an arithmetic reference model.
module tb_norm_round_fp;
   import fp_pkg::*;

   localparam int W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en_norm = 1'b0;
   logic              rst_norm_n = 1'b1;
   logic              mux_norm = 1'b0;
   logic [21:0]       prod = '0;
   logic signed [6:0] exp_in = '0;
   logic [9:0]        fraction;
   logic [4:0]        exponent;
   logic              normal_done, round_o, overflow, underflow;
   norm_state_t       state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   // reference model state: held outputs plus rounded mantissa and exponent
   int m_frac, m_expo, m_ovf, m_unf, m_round, m_r, m_e, m_lat;

   norm_round_fp #(.SIZE(16)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en_norm     (en_norm),
      .i_rst_norm_n  (rst_norm_n),
      .i_mux_norm    (mux_norm),
      .i_prod        (prod),
      .i_exp         (exp_in),
      .o_fraction    (fraction),
      .o_exponent    (exponent),
      .o_normal_done (normal_done),
      .o_round       (round_o),
      .o_overflow    (overflow),
      .o_underflow   (underflow),
      .o_state       (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [21:0]       prod;
      logic signed [6:0] ex;
      logic [9:0]        frac;
      logic [4:0]        expo;
      logic              rnd;
      logic              ovf;
      logic              unf;
      int                lat;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_frac = 0; m_expo = 0; m_ovf = 0; m_unf = 0; m_round = 0; m_r = 0; m_e = 0; m_lat = 0;
   endtask

   // Value-level model: find the leading one, then round the discarded part against one half.
   task automatic model_load(input logic mux, input logic [21:0] p_in, input logic signed [6:0] ex);
      longint w;
      int e, k, q, rem, r;
      bit up;
      if (mux) begin
         w = longint'(p_in);
         e = int'(ex) + 1;
      end else begin
         w = longint'(m_r) << 10;
         e = m_e + 1;
      end
      if (w == 0) begin
         k = 0;
         r = 1024;
      end else begin
         k = 21 - ($clog2(w + 1) - 1);
         w = w << k;
         e = e - k;
         q = int'(w >> 11);
         rem = int'(w % 2048);
         up = (rem > 1024) || (rem == 1024 && (q % 2) == 1);
         r = q + int'(up);
      end
      m_lat = k + 2;
      m_r = r;
      m_e = e;
      m_round = (r >= 2048) ? 1 : 0;
      if (m_round == 0) begin
         if (w == 0) begin
            m_frac = 0; m_expo = 0; m_ovf = 0; m_unf = 0;
         end else if (e >= 31) begin
            m_frac = 0; m_expo = 31; m_ovf = 1; m_unf = 0;
         end else if (e <= 0) begin
            m_frac = 0; m_expo = 0; m_ovf = 0; m_unf = 1;
         end else begin
            m_frac = r % 1024; m_expo = e; m_ovf = 0; m_unf = 0;
         end
      end
   endtask

   // Load, then wait for done; lat counts edges after the load edge, d0 is done just after it.
   task automatic apply(input logic mux, input logic [21:0] p_in, input logic signed [6:0] ex,
                        output int lat, output logic d0);
      @(negedge clk);
      rst_norm_n = 1'b0; mux_norm = mux; prod = p_in; exp_in = ex; en_norm = 1'b1;
      model_load(mux, p_in, ex);
      @(negedge clk);
      rst_norm_n = 1'b1;
      d0 = normal_done;
      lat = 0;
      while (!normal_done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [W-1:0] pack(input int lat, input int rnd, input int ovf, input int unf,
                                         input int expo, input int frac);
      return {6'd0, lat[7:0], rnd[0], ovf[0], unf[0], expo[4:0], frac[9:0]};
   endfunction

   initial begin
      int lat;
      logic d0;
      logic [21:0] rp;
      logic [10:0] a, b;
      logic signed [6:0] rx;

      tbl[0] = '{22'h100000,  7'sd0,  10'h000, 5'd0,  1'b0, 1'b0, 1'b1, 3};
      tbl[1] = '{22'h240000,  7'sd15, 10'h080, 5'd16, 1'b0, 1'b0, 1'b0, 2};
      tbl[2] = '{22'h100000,  7'sd15, 10'h000, 5'd15, 1'b0, 1'b0, 1'b0, 3};
      tbl[3] = '{22'h240000,  7'sd30, 10'h000, 5'd31, 1'b0, 1'b1, 1'b0, 2};
      tbl[4] = '{22'h000000,  7'sd15, 10'h000, 5'd0,  1'b0, 1'b0, 1'b0, 2};
      tbl[5] = '{22'h240000, -7'sd2,  10'h000, 5'd0,  1'b0, 1'b0, 1'b1, 2};
      tbl[6] = '{22'h200400,  7'sd15, 10'h000, 5'd16, 1'b0, 1'b0, 1'b0, 2};
      tbl[7] = '{22'h200C00,  7'sd15, 10'h002, 5'd16, 1'b0, 1'b0, 1'b0, 2};
      tbl[8] = '{22'h0C0000,  7'sd15, 10'h200, 5'd14, 1'b0, 1'b0, 1'b0, 4};
      tbl[9] = '{22'h240000,  7'sd29, 10'h080, 5'd30, 1'b0, 1'b0, 1'b0, 2};

      // clock/reset
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_outputs", {normal_done, round_o, overflow, underflow, exponent, fraction}, '0);
      check("reset_state", state, ST_IDLE);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_done", {normal_done, state}, {1'b0, ST_IDLE});

      // directed table
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, tbl[i].prod, tbl[i].ex, lat, d0);
         check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         check($sformatf("tbl%0d_frac", i), fraction, tbl[i].frac);
         check($sformatf("tbl%0d_expo", i), exponent, tbl[i].expo);
         check($sformatf("tbl%0d_flags", i), {round_o, overflow, underflow},
               {tbl[i].rnd, tbl[i].ovf, tbl[i].unf});
      end

      // tie with carry: outputs keep the previous result, then a reload finishes it
      apply(1'b1, 22'h3FFC00, 7'sd15, lat, d0);
      check("carry_lat", lat, 2);
      check("carry_round", round_o, 1'b1);
      check("carry_held", {exponent, fraction}, {5'd30, 10'h080});
      repeat (2) @(negedge clk);
      check("carry_round_stable", {normal_done, round_o}, 2'b11);
      apply(1'b0, 22'h0, 7'sd0, lat, d0);
      check("reload_lat", lat, 2);
      check("reload_result", {round_o, overflow, underflow, exponent, fraction},
            {3'b000, 5'd17, 10'h000});

      // enable held low in SHIFT: nothing moves
      @(negedge clk);
      rst_norm_n = 1'b0; mux_norm = 1'b1; prod = 22'h100000; exp_in = 7'sd15; en_norm = 1'b0;
      model_load(1'b1, 22'h100000, 7'sd15);
      @(negedge clk);
      rst_norm_n = 1'b1;
      repeat (5) @(negedge clk);
      check("hold_no_done", {normal_done, state}, {1'b0, ST_SHIFT});
      en_norm = 1'b1;
      lat = 0;
      while (!normal_done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("hold_resume_lat", lat, 3);
      check("hold_result", {exponent, fraction}, {5'd15, 10'h000});

      // load while in DONE drops done on the next edge
      apply(1'b1, 22'h240000, 7'sd15, lat, d0);
      check("done_drop", d0, 1'b0);
      check("done_reload_lat", lat, 2);
      check("done_reload_result", {exponent, fraction}, {5'd16, 10'h080});

      // asynchronous reset mid-SHIFT
      @(negedge clk);
      rst_norm_n = 1'b0; mux_norm = 1'b1; prod = 22'h000001; exp_in = 7'sd15; en_norm = 1'b1;
      @(negedge clk);
      rst_norm_n = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_reset_state", state, ST_SHIFT);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {normal_done, round_o, overflow, underflow, exponent, fraction}, '0);
      check("async_reset_state", state, ST_IDLE);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset_idle", {normal_done, state}, {1'b0, ST_IDLE});

      // randomized products against the model via the expected queue
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            a = 11'h400 | 11'($urandom_range(0, 1023));
            b = 11'h400 | 11'($urandom_range(0, 1023));
            rp = 22'(a * b);
         end else begin
            rp = 22'($urandom);
         end
         rx = 7'($urandom_range(0, 44)) - 7'sd4;
         apply(1'b1, rp, rx, lat, d0);
         exp_q.push_back(pack(m_lat, m_round, m_ovf, m_unf, m_expo, m_frac));
         check($sformatf("rand%0d p=%h e=%0d", n, rp, rx),
               pack(lat, int'(round_o), int'(overflow), int'(underflow), int'(exponent), int'(fraction)),
               exp_q.pop_front());
         if (m_round != 0) begin
            apply(1'b0, 22'h0, 7'sd0, lat, d0);
            exp_q.push_back(pack(m_lat, m_round, m_ovf, m_unf, m_expo, m_frac));
            check($sformatf("rand%0d_reload", n),
                  pack(lat, int'(round_o), int'(overflow), int'(underflow), int'(exponent), int'(fraction)),
                  exp_q.pop_front());
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
